// File: rtl/branch_rs_pkg.sv
// ---------------------------------------------------------------------------
// branch_rs_pkg
// Shared types and constants for the branch reservation station:
//   - core-wide widths (opcode, data word, ROB, physical register file)
//   - cdb_t   : registered common-data-bus broadcast {valid, dest, flags, result}
//   - branch_rs_entry_t : one reservation-station slot
// ---------------------------------------------------------------------------
package branch_rs_pkg;

  localparam int WIDTH_OP     = 4;
  localparam int WORD_SIZE_P  = 16;
  localparam int ROB_ENTRY    = 16;
  localparam int NUM_PHYS_REG = 32;
  localparam int FLAGS_W      = 4;
  localparam int BRS_DEPTH    = 4;

  localparam int TAG_W_P = $clog2(NUM_PHYS_REG);
  localparam int ROB_W_P = $clog2(ROB_ENTRY);

  typedef enum logic [WIDTH_OP-1:0] {
    OP_BCC = 4'd1,
    OP_BL  = 4'd2,
    OP_BR  = 4'd3
  } br_opcode_e;

  typedef struct packed {
    logic                   valid;
    logic [TAG_W_P-1:0]     dest;
    logic [FLAGS_W-1:0]     flags;
    logic [WORD_SIZE_P-1:0] result;
  } cdb_t;

  localparam int CDB_WIDTH = $bits(cdb_t);

  typedef struct packed {
    logic                   valid;
    logic [WIDTH_OP-1:0]    opcode;
    logic [WORD_SIZE_P-1:0] pc;
    logic [WORD_SIZE_P-1:0] op1;
    logic [WORD_SIZE_P-1:0] op2;
    logic [TAG_W_P-1:0]     tag1;
    logic [TAG_W_P-1:0]     tag2;
    logic                   rdy1;
    logic                   rdy2;
    logic [ROB_W_P-1:0]     rob_dest;
    logic [TAG_W_P-1:0]     reg_dest;
  } branch_rs_entry_t;

endpackage

// File: rtl/branch_rs_if.sv
// ---------------------------------------------------------------------------
// branch_rs_if
// Dispatch-side and issue-side signals of the branch reservation station.
//   master : dispatch stage / branch FU environment (drives disp_*_i,
//            observes disp_ready_o and the exe/issue outputs)
//   slave  : the reservation station itself
// ---------------------------------------------------------------------------
interface branch_rs_if;
  import branch_rs_pkg::*;

  // dispatch
  logic                   disp_v_i;
  logic                   disp_ready_o;
  logic [WIDTH_OP-1:0]    disp_opcode_i;
  logic [WORD_SIZE_P-1:0] disp_pc_i;
  logic [WORD_SIZE_P-1:0] disp_op1_i;
  logic [WORD_SIZE_P-1:0] disp_op2_i;
  logic [TAG_W_P-1:0]     disp_tag1_i;
  logic [TAG_W_P-1:0]     disp_tag2_i;
  logic                   disp_rdy1_i;
  logic                   disp_rdy2_i;
  logic [ROB_W_P-1:0]     disp_rob_dest_i;
  logic [TAG_W_P-1:0]     disp_reg_dest_i;

  // issue to branch FU
  logic                   exe_v_o;
  logic [WIDTH_OP-1:0]    opcode_o;
  logic [WORD_SIZE_P-1:0] pc_o;
  logic [WORD_SIZE_P-1:0] operand1_o;
  logic [WORD_SIZE_P-1:0] operand2_o;
  logic [ROB_W_P-1:0]     rob_dest_o;
  logic [TAG_W_P-1:0]     reg_dest_o;

  modport master (
    output disp_v_i, disp_opcode_i, disp_pc_i, disp_op1_i, disp_op2_i,
           disp_tag1_i, disp_tag2_i, disp_rdy1_i, disp_rdy2_i,
           disp_rob_dest_i, disp_reg_dest_i,
    input  disp_ready_o,
    input  exe_v_o, opcode_o, pc_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
  );

  modport slave (
    input  disp_v_i, disp_opcode_i, disp_pc_i, disp_op1_i, disp_op2_i,
           disp_tag1_i, disp_tag2_i, disp_rdy1_i, disp_rdy2_i,
           disp_rob_dest_i, disp_reg_dest_i,
    output disp_ready_o,
    output exe_v_o, opcode_o, pc_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
  );

endinterface

// File: rtl/rs_operand_wakeup.sv
// ---------------------------------------------------------------------------
// rs_operand_wakeup
// Combinational operand wakeup: if the operand is still waiting and the CDB
// broadcasts its producer tag, the broadcast result replaces the value and
// the operand becomes ready. Otherwise the operand passes through unchanged.
//   i_cdb_v / i_cdb_dest / i_cdb_result : CDB broadcast
//   i_rdy / i_tag / i_val               : current operand state
//   o_rdy / o_val                       : operand state after wakeup
// ---------------------------------------------------------------------------
module rs_operand_wakeup #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic              i_cdb_v,
  input  logic [TAG_W-1:0]  i_cdb_dest,
  input  logic [DATA_W-1:0] i_cdb_result,
  input  logic              i_rdy,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_val,
  output logic              o_rdy,
  output logic [DATA_W-1:0] o_val
);

  logic w_hit;

  assign w_hit = i_cdb_v && !i_rdy && (i_tag == i_cdb_dest);
  assign o_rdy = i_rdy || w_hit;
  assign o_val = w_hit ? i_cdb_result : i_val;

endmodule

// File: rtl/branch_rs.sv
// ---------------------------------------------------------------------------
// branch_rs
// In-order reservation station for branch ops. Dispatched branches are held
// in a circular queue, missing operands are captured from the CDB, and the
// head branch is issued to the branch FU once both its operands are ready.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   flush_i          : synchronous discard of all entries
//   cdb_i            : registered CDB broadcast (flags ignored)
//   bus (slave)      : dispatch inputs / disp_ready_o and registered issue
//                      outputs exe_v_o, opcode_o, pc_o, operand1/2_o,
//                      rob_dest_o, reg_dest_o
// ---------------------------------------------------------------------------
module branch_rs
  import branch_rs_pkg::*;
#(
  parameter int DEPTH = BRS_DEPTH,
  parameter int TAG_W = TAG_W_P,
  parameter int ROB_W = ROB_W_P
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        flush_i,
  input  cdb_t        cdb_i,
  branch_rs_if.slave  bus
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic                   r_exe_v;
  logic [WIDTH_OP-1:0]    r_opcode;
  logic [WORD_SIZE_P-1:0] r_pc;
  logic [WORD_SIZE_P-1:0] r_operand1;
  logic [WORD_SIZE_P-1:0] r_operand2;
  logic [ROB_W-1:0]       r_rob_dest;
  logic [TAG_W-1:0]       r_reg_dest;

  branch_rs_entry_t w_entries [DEPTH];
  branch_rs_entry_t w_head;
  branch_rs_entry_t w_disp_entry;
  logic             w_disp;
  logic             w_issue;
  logic             w_disp_rdy1;
  logic             w_disp_rdy2;
  logic [WORD_SIZE_P-1:0] w_disp_op1;
  logic [WORD_SIZE_P-1:0] w_disp_op2;
  logic [FLAGS_W-1:0]     w_unused_flags;

  assign w_unused_flags   = cdb_i.flags;

  // Ready depends only on the registered count, never on a same-cycle issue.
  assign bus.disp_ready_o = (r_count != CNT_FULL);
  assign w_disp           = bus.disp_v_i && bus.disp_ready_o;

  assign w_head  = w_entries[r_head];
  assign w_issue = w_head.valid && w_head.rdy1 && w_head.rdy2;

  // Dispatch path: a broadcast in the dispatch cycle is captured directly.
  rs_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(WORD_SIZE_P)) u_disp_wk1 (
    .i_cdb_v(cdb_i.valid), .i_cdb_dest(cdb_i.dest), .i_cdb_result(cdb_i.result),
    .i_rdy(bus.disp_rdy1_i), .i_tag(bus.disp_tag1_i), .i_val(bus.disp_op1_i),
    .o_rdy(w_disp_rdy1), .o_val(w_disp_op1)
  );

  rs_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(WORD_SIZE_P)) u_disp_wk2 (
    .i_cdb_v(cdb_i.valid), .i_cdb_dest(cdb_i.dest), .i_cdb_result(cdb_i.result),
    .i_rdy(bus.disp_rdy2_i), .i_tag(bus.disp_tag2_i), .i_val(bus.disp_op2_i),
    .o_rdy(w_disp_rdy2), .o_val(w_disp_op2)
  );

  always_comb begin
    w_disp_entry          = '0;
    w_disp_entry.valid    = 1'b1;
    w_disp_entry.opcode   = bus.disp_opcode_i;
    w_disp_entry.pc       = bus.disp_pc_i;
    w_disp_entry.op1      = w_disp_op1;
    w_disp_entry.op2      = w_disp_op2;
    w_disp_entry.tag1     = bus.disp_tag1_i;
    w_disp_entry.tag2     = bus.disp_tag2_i;
    w_disp_entry.rdy1     = w_disp_rdy1;
    w_disp_entry.rdy2     = w_disp_rdy2;
    w_disp_entry.rob_dest = bus.disp_rob_dest_i;
    w_disp_entry.reg_dest = bus.disp_reg_dest_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      branch_rs_entry_t       r_entry;
      logic                   w_rdy1;
      logic                   w_rdy2;
      logic [WORD_SIZE_P-1:0] w_op1;
      logic [WORD_SIZE_P-1:0] w_op2;
      logic                   w_wr;
      logic                   w_clr;

      rs_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(WORD_SIZE_P)) u_wk1 (
        .i_cdb_v(cdb_i.valid), .i_cdb_dest(cdb_i.dest), .i_cdb_result(cdb_i.result),
        .i_rdy(r_entry.rdy1), .i_tag(r_entry.tag1), .i_val(r_entry.op1),
        .o_rdy(w_rdy1), .o_val(w_op1)
      );

      rs_operand_wakeup #(.TAG_W(TAG_W), .DATA_W(WORD_SIZE_P)) u_wk2 (
        .i_cdb_v(cdb_i.valid), .i_cdb_dest(cdb_i.dest), .i_cdb_result(cdb_i.result),
        .i_rdy(r_entry.rdy2), .i_tag(r_entry.tag2), .i_val(r_entry.op2),
        .o_rdy(w_rdy2), .o_val(w_op2)
      );

      assign w_wr  = w_disp  && (r_tail == PTR_W'(gi));
      assign w_clr = w_issue && (r_head == PTR_W'(gi));

      // The tail slot of a non-full queue is never the issuing head, so
      // write and clear cannot target the same slot in one cycle.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_entry <= '0;
        end else if (flush_i) begin
          r_entry.valid <= 1'b0;
        end else if (w_wr) begin
          r_entry <= w_disp_entry;
        end else if (r_entry.valid) begin
          r_entry.valid <= !w_clr;
          r_entry.rdy1  <= w_rdy1;
          r_entry.op1   <= w_op1;
          r_entry.rdy2  <= w_rdy2;
          r_entry.op2   <= w_op2;
        end
      end

      assign w_entries[gi] = r_entry;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_disp)  r_tail <= r_tail + PTR_W'(1);
      if (w_issue) r_head <= r_head + PTR_W'(1);
      unique case ({w_disp, w_issue})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue registers: data outputs hold their last issued values when idle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_exe_v    <= 1'b0;
      r_opcode   <= '0;
      r_pc       <= '0;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_rob_dest <= '0;
      r_reg_dest <= '0;
    end else if (flush_i) begin
      r_exe_v <= 1'b0;
    end else if (w_issue) begin
      r_exe_v    <= 1'b1;
      r_opcode   <= w_head.opcode;
      r_pc       <= w_head.pc;
      r_operand1 <= w_head.op1;
      r_operand2 <= w_head.op2;
      r_rob_dest <= w_head.rob_dest;
      r_reg_dest <= w_head.reg_dest;
    end else begin
      r_exe_v <= 1'b0;
    end
  end

  assign bus.exe_v_o    = r_exe_v;
  assign bus.opcode_o   = r_opcode;
  assign bus.pc_o       = r_pc;
  assign bus.operand1_o = r_operand1;
  assign bus.operand2_o = r_operand2;
  assign bus.rob_dest_o = r_rob_dest;
  assign bus.reg_dest_o = r_reg_dest;

endmodule

// File: tb/tb_branch_rs.sv
// ---------------------------------------------------------------------------
// tb_branch_rs
// Directed scenarios followed by random traffic on branch_rs. Expected
// behaviour comes from a program-ordered queue model of waiting branches.
// ---------------------------------------------------------------------------
module tb_branch_rs;
  import branch_rs_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] pc;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  tag1;
    logic [4:0]  tag2;
    logic        rdy1;
    logic        rdy2;
    logic [3:0]  rob;
    logic [4:0]  rd;
  } m_ent_t;

  logic clk;
  logic reset_n;
  logic flush;
  cdb_t cdb;

  branch_rs_if bus ();

  branch_rs #(.DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .flush_i(flush),
    .cdb_i(cdb),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;

  m_ent_t      m_q[$];
  logic        m_exe_v = 1'b0;
  logic [60:0] m_data  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.disp_v_i = 1'b0;
    cdb.valid    = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic disp(input logic [3:0] opc, input logic [15:0] pc,
                      input logic [15:0] op1, input logic [15:0] op2,
                      input logic [4:0] t1, input logic [4:0] t2,
                      input logic r1, input logic r2);
    seq++;
    bus.disp_v_i        = 1'b1;
    bus.disp_opcode_i   = opc;
    bus.disp_pc_i       = pc;
    bus.disp_op1_i      = op1;
    bus.disp_op2_i      = op2;
    bus.disp_tag1_i     = t1;
    bus.disp_tag2_i     = t2;
    bus.disp_rdy1_i     = r1;
    bus.disp_rdy2_i     = r2;
    bus.disp_rob_dest_i = 4'(seq);
    bus.disp_reg_dest_i = 5'(seq * 3);
  endtask

  task automatic bcast(input logic [4:0] dest, input logic [15:0] res);
    cdb.valid  = 1'b1;
    cdb.dest   = dest;
    cdb.flags  = 4'(res);
    cdb.result = res;
  endtask

  // Advance the model by one clock using the currently driven inputs, clock
  // the DUT, then compare every visible output against the model.
  task automatic step();
    m_ent_t e;
    logic   full;
    logic   iss;
    full = (m_q.size() == DEPTH);
    iss  = (m_q.size() != 0) && m_q[0].rdy1 && m_q[0].rdy2;
    if (flush) begin
      m_q.delete();
      m_exe_v = 1'b0;
    end else begin
      if (iss) begin
        e       = m_q.pop_front();
        m_exe_v = 1'b1;
        m_data  = {e.opc, e.pc, e.op1, e.op2, e.rob, e.rd};
      end else begin
        m_exe_v = 1'b0;
      end
      for (int i = 0; i < m_q.size(); i++) begin
        e = m_q[i];
        if (cdb.valid && !e.rdy1 && e.tag1 == cdb.dest) begin e.rdy1 = 1'b1; e.op1 = cdb.result; end
        if (cdb.valid && !e.rdy2 && e.tag2 == cdb.dest) begin e.rdy2 = 1'b1; e.op2 = cdb.result; end
        m_q[i] = e;
      end
      if (bus.disp_v_i && !full) begin
        e.opc  = bus.disp_opcode_i;  e.pc   = bus.disp_pc_i;
        e.op1  = bus.disp_op1_i;     e.op2  = bus.disp_op2_i;
        e.tag1 = bus.disp_tag1_i;    e.tag2 = bus.disp_tag2_i;
        e.rdy1 = bus.disp_rdy1_i;    e.rdy2 = bus.disp_rdy2_i;
        e.rob  = bus.disp_rob_dest_i; e.rd  = bus.disp_reg_dest_i;
        if (cdb.valid && !e.rdy1 && e.tag1 == cdb.dest) begin e.rdy1 = 1'b1; e.op1 = cdb.result; end
        if (cdb.valid && !e.rdy2 && e.tag2 == cdb.dest) begin e.rdy2 = 1'b1; e.op2 = cdb.result; end
        m_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("exe_v", 64'(bus.exe_v_o), 64'(m_exe_v));
    check("disp_ready", 64'(bus.disp_ready_o), 64'(m_q.size() != DEPTH));
    check("count", 64'(dut.r_count), 64'(m_q.size()));
    check("issue_data", 64'({bus.opcode_o, bus.pc_o, bus.operand1_o, bus.operand2_o,
                             bus.rob_dest_o, bus.reg_dest_o}), 64'(m_data));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_exe_v = 1'b0;
    m_data  = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    cdb = '0;
    disp(OP_BCC, 16'h0, 16'h0, 16'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    bus.disp_v_i = 1'b0;
    seq = 0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst_exe_v", 64'(bus.exe_v_o), 64'd0);
    check("rst_ready", 64'(bus.disp_ready_o), 64'd1);
    check("rst_count", 64'(dut.r_count), 64'd0);
    check("rst_pc", 64'(bus.pc_o), 64'd0);
    #2 reset_n = 1'b1;
    step();

    // fully ready BCC issues one cycle after dispatch
    disp(OP_BCC, 16'h0010, 16'h0001, 16'h0004, 5'd0, 5'd0, 1'b1, 1'b1);
    step();
    idle();
    step();
    check("t1_exe_v", 64'(bus.exe_v_o), 64'd1);
    check("t1_pc", 64'(bus.pc_o), 64'h0010);
    check("t1_op2", 64'(bus.operand2_o), 64'h0004);
    step();
    check("t1_exe_v_drop", 64'(bus.exe_v_o), 64'd0);

    // BR waiting on tag 5, broadcast three cycles later
    disp(OP_BR, 16'h0020, 16'h0011, 16'h0000, 5'd0, 5'd5, 1'b1, 1'b0);
    step();
    idle();
    step(); step();
    bcast(5'd5, 16'h1234);
    step();
    idle();
    step();
    check("t2_exe_v", 64'(bus.exe_v_o), 64'd1);
    check("t2_op2", 64'(bus.operand2_o), 64'h1234);

    // non-ready head blocks a ready younger entry
    disp(OP_BCC, 16'h0A00, 16'h0000, 16'h0002, 5'd3, 5'd0, 1'b0, 1'b1);
    step();
    disp(OP_BL, 16'h0B00, 16'h0003, 16'h0004, 5'd0, 5'd0, 1'b1, 1'b1);
    step();
    idle();
    step(); step();
    check("t3_blocked", 64'(bus.exe_v_o), 64'd0);
    bcast(5'd3, 16'hAAAA);
    step();
    idle();
    step();
    check("t3_a_pc", 64'(bus.pc_o), 64'h0A00);
    check("t3_a_op1", 64'(bus.operand1_o), 64'hAAAA);
    step();
    check("t3_b_pc", 64'(bus.pc_o), 64'h0B00);
    check("t3_b_exe_v", 64'(bus.exe_v_o), 64'd1);

    // dispatch / CDB collision
    disp(OP_BR, 16'h0C00, 16'h0000, 16'h0007, 5'd7, 5'd0, 1'b0, 1'b1);
    bcast(5'd7, 16'hBEEF);
    step();
    idle();
    step();
    check("t4_exe_v", 64'(bus.exe_v_o), 64'd1);
    check("t4_op1", 64'(bus.operand1_o), 64'hBEEF);

    // fill, reject when full, then wrap the pointers
    for (int i = 0; i < DEPTH; i++) begin
      disp(OP_BCC, 16'h1000 + 16'(i), 16'h0, 16'h5, 5'(10 + i), 5'd0, 1'b0, 1'b1);
      step();
    end
    check("t5_full", 64'(bus.disp_ready_o), 64'd0);
    disp(OP_BL, 16'hDEAD, 16'h1, 16'h2, 5'd0, 5'd0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      disp(OP_BR, 16'h2000 + 16'(i), 16'h9, 16'h8, 5'd0, 5'd0, 1'b1, 1'b1);
      bcast(5'(10 + i), 16'h3000 + 16'(i));
      step();
    end
    idle();
    repeat (6) step();

    // flush overrides dispatch and issue in the same cycle
    disp(OP_BCC, 16'h4000, 16'h0, 16'h1, 5'd20, 5'd0, 1'b0, 1'b1);
    step();
    disp(OP_BCC, 16'h4001, 16'h1, 16'h1, 5'd0, 5'd0, 1'b1, 1'b1);
    step();
    disp(OP_BCC, 16'h4002, 16'h1, 16'h1, 5'd0, 5'd0, 1'b1, 1'b1);
    bcast(5'd20, 16'h0042);
    step();
    idle();
    disp(OP_BL, 16'h4003, 16'h1, 16'h1, 5'd0, 5'd0, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    check("t6_flush_count", 64'(dut.r_count), 64'd0);
    check("t6_flush_exe_v", 64'(bus.exe_v_o), 64'd0);
    check("t6_flush_ready", 64'(bus.disp_ready_o), 64'd1);
    idle();

    // asynchronous reset with entries queued and an issue on the outputs
    disp(OP_BR, 16'h5000, 16'h7, 16'h7, 5'd0, 5'd0, 1'b1, 1'b1);
    step();
    disp(OP_BR, 16'h5001, 16'h7, 16'h7, 5'd1, 5'd0, 1'b0, 1'b1);
    step();
    idle();
    check("t7_pre_exe_v", 64'(bus.exe_v_o), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("t7_rst_exe_v", 64'(bus.exe_v_o), 64'd0);
    check("t7_rst_pc", 64'(bus.pc_o), 64'd0);
    check("t7_rst_ready", 64'(bus.disp_ready_o), 64'd1);
    check("t7_rst_count", 64'(dut.r_count), 64'd0);
    #10 reset_n = 1'b1;
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0)
        disp(4'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 16'($urandom),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        bus.disp_v_i = 1'b0;
      if ($urandom_range(0, 1) != 0) bcast(5'($urandom_range(0, 7)), 16'($urandom));
      else cdb.valid = 1'b0;
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
- In-order reservation station for branch ops, sitting between dispatch and the branch functional unit.
- Holds dispatched branches, captures missing operands by snooping the registered CDB broadcast, and issues the oldest branch once both of its operands are ready.
- Drives the branch FU's execute inputs: valid, opcode, pc, operands, ROB/register destinations.
- Branches issue strictly in program order.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- TAG_W, $clog2(NUM_PHYS_REG), physical register tag width.
- ROB_W, $clog2(ROB_ENTRY), ROB index width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all entries (mispredict recovery)
- disp_v_i  in  1  dispatch request valid
- disp_ready_o  out  1  entry available
- disp_opcode_i  in  WIDTH_OP  branch opcode (BCC/BL/BR)
- disp_pc_i  in  WORD_SIZE_P  branch pc
- disp_op1_i / disp_op2_i  in  WORD_SIZE_P  operand value, valid when its rdy bit is set
- disp_tag1_i / disp_tag2_i  in  TAG_W  producer tag, used when its rdy bit is clear
- disp_rdy1_i / disp_rdy2_i  in  1  operand already available
- disp_rob_dest_i  in  ROB_W  ROB index
- disp_reg_dest_i  in  TAG_W  destination physical register (BL link)
- cdb_i  in  CDB_WIDTH  broadcast {valid, dest, flags, result}
- exe_v_o  out  1  issue valid to the FU
- opcode_o  out  WIDTH_OP  issued opcode
- pc_o  out  WORD_SIZE_P  issued pc
- operand1_o / operand2_o  out  WORD_SIZE_P  issued operands
- rob_dest_o  out  ROB_W  issued ROB index
- reg_dest_o  out  TAG_W  issued destination register

Behaviour:
- Reset:
  - Head, tail and count are 0; all entry valid bits are 0.
  - All outputs are 0, except disp_ready_o = 1.
- Storage: circular buffer with head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, plus a count register of width $clog2(DEPTH)+1.
- disp_ready_o = (count != DEPTH). It is combinational from registered count only; it does not depend on a same-cycle issue.
- Dispatch:
  - Fires when disp_v_i && disp_ready_o.
  - Writes the entry at tail and sets its valid bit; tail increments.
  - If disp_v_i is high while disp_ready_o is low, the request is ignored and state is unchanged.
- Wakeup (every cycle, every valid entry):
  - If cdb_i.valid, and an operand is not ready, and its tag == cdb_i.dest: store cdb_i.result and set its rdy bit.
  - Both operands of one entry may wake on the same broadcast.
- Dispatch–CDB collision: if a dispatching operand has rdy = 0 and its tag matches a valid cdb_i in the same cycle, the entry is written with rdy = 1 and value = cdb_i.result.
- Issue:
  - Fires when the head entry is valid and both of its rdy bits are set in registered state. The same-cycle CDB value is not bypassed, so a woken entry issues one cycle later.
  - On issue, all issue outputs are registered from the head entry with exe_v_o = 1; the head valid bit clears and head increments.
  - Otherwise exe_v_o = 0 and the data outputs hold their last values.
- Latency: an entry dispatched fully ready at edge t is presented with exe_v_o = 1 after edge t+1.
- Simultaneous dispatch and issue: count is unchanged. When count == DEPTH, dispatch is blocked that cycle even though issue frees an entry.
- Stall behaviour: only the head may issue. A non-ready head blocks younger ready entries (in-order resolution).
- flush_i (synchronous):
  - Clears all valid bits, head, tail and count; exe_v_o is registered 0.
  - Overrides a same-cycle dispatch, wakeup and issue.
  - disp_ready_o = 1 the next cycle.
- Asynchronous reset mid-operation clears everything immediately, regardless of clk_i.
- cdb_i with valid = 0 is ignored. The flags field is unused.

Decomposition:
- Shared package:
  - Add a branch_rs_entry_t struct {valid, opcode, pc, op1, op2, tag1, tag2, rdy1, rdy2, rob_dest, reg_dest}.
  - Add a BRS_DEPTH constant.
  - Reuse the existing cdb_t and the WIDTH_OP, WORD_SIZE_P, ROB_ENTRY and NUM_PHYS_REG constants.
- Sub-module rs_operand_wakeup: per-operand tag compare plus value capture, instantiated 2×DEPTH times, plus once per operand on the dispatch path.

Test Plan:
- Reset then dispatch BCC (pc = 0x0010, op2 = 0x0004, both rdy) → exe_v_o = 1 the cycle after dispatch, pc_o = 0x0010, operand2_o = 0x0004; next cycle exe_v_o = 0.
- Dispatch BR with tag2 = 5 not ready; three cycles later drive cdb_i {valid=1, dest=5, result=0x1234} → exe_v_o = 1 one cycle after the CDB cycle, operand2_o = 0x1234.
- Dispatch A (waiting on tag 3), then B (ready) → nothing issues; CDB dest = 3 → A issues, then B issues the next cycle, in order.
- Dispatch with tag1 = 7 while cdb_i {valid=1, dest=7, result=0xBEEF} in the same cycle → the entry issues after the next edge with operand1_o = 0xBEEF.
- Fill 4 non-ready entries → disp_ready_o = 0 and a fifth disp_v_i is ignored; wrap pointers by issuing all 4 and dispatching 4 more → correct order.
- With 3 entries queued, assert flush_i together with disp_v_i and a head-ready issue → next cycle count = 0, exe_v_o = 0, disp_ready_o = 1; reset_n_i low mid-queue → outputs 0 immediately.
